// File: rtl/game_flow_sm.sv
// Game flow controller: menu -> mode select -> controls -> level banner -> gameplay -> over/won.
// Optional pause state compiled in with `define GAME_PAUSE_EN.
module game_flow_sm #(
    parameter int NUM_LEVELS     = 3,
    parameter int NUM_MODES      = 2,
    parameter int LEVEL_DSP_SEC  = 3,
    parameter int GAMEOVER_DLY_S = 3,
    localparam int MODE_W = $clog2(NUM_MODES),
    localparam int LVL_W  = $clog2(NUM_LEVELS + 1)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              enter_key_pressed,
    input  logic              up_key_pressed,
    input  logic              down_key_pressed,
    input  logic              one_sec_pulse,
    input  logic              timer_ended,
    input  logic              player_died,
    input  logic              level_cleared,
    input  logic              menu_DR,
    input  logic [7:0]        menu_RGB,
    input  logic              mode_DR,
    input  logic [7:0]        mode_RGB,
    input  logic              controls_DR,
    input  logic [7:0]        controls_RGB,
    input  logic              level_DR,
    input  logic [7:0]        level_RGB,
    input  logic              gameover_DR,
    input  logic [7:0]        gameover_RGB,
    input  logic              won_DR,
    input  logic [7:0]        won_RGB,
    input  logic [7:0]        RGB_MIF,
    output logic [7:0]        RGBOut,
    output logic              game_on,
    output logic [MODE_W-1:0] mode_sel,
    output logic [LVL_W-1:0]  level_sel,
    output logic              game_over_type,
    output logic              paused
);

    // Handshake-free block: keys are levels, one_sec_pulse and level_cleared are 1-cycle strobes.
    typedef enum logic [3:0] {
        S_MAIN_MENU    = 4'd0,
        S_MODE_SEL     = 4'd1,
        S_CONTROLS     = 4'd2,
        S_LEVEL_DSP    = 4'd3,
        S_GAMEPLAY     = 4'd4,
        S_GAMEOVER_DLY = 4'd5,
        S_GAMEOVER     = 4'd6,
        S_GAME_WON     = 4'd7
`ifdef GAME_PAUSE_EN
        , S_PAUSED     = 4'd8
`endif
    } state_t;

    localparam logic [3:0]        LVL_CNT   = 4'(LEVEL_DSP_SEC);
    localparam logic [3:0]        DLY_CNT   = 4'(GAMEOVER_DLY_S);
    localparam logic [MODE_W-1:0] MODE_MAX  = MODE_W'(NUM_MODES - 1);
    localparam logic [LVL_W-1:0]  LVL_LAST  = LVL_W'(NUM_LEVELS);
    localparam logic [LVL_W-1:0]  LVL_FIRST = LVL_W'(1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          rgb_q, rgb_d;
    logic                game_on_q, game_on_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                got_q, got_d;
    logic                enter_q, up_q, down_q;
    logic                enter_rise, up_rise, down_rise;
`ifdef GAME_PAUSE_EN
    logic                paused_q, paused_d;
`endif

    assign enter_rise = enter_key_pressed & ~enter_q;
    assign up_rise    = up_key_pressed & ~up_q;
    assign down_rise  = down_key_pressed & ~down_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        game_on_d = game_on_q;
        mode_d    = mode_q;
        level_d   = level_q;
        got_d     = got_q;
        rgb_d     = RGB_MIF;
`ifdef GAME_PAUSE_EN
        paused_d  = paused_q;
`endif
        case (state_q)
            S_MAIN_MENU: begin
                level_d = LVL_FIRST;
                if (menu_DR) rgb_d = menu_RGB;
                if (enter_rise) state_d = S_MODE_SEL;
            end
            S_MODE_SEL: begin
                if (mode_DR) rgb_d = mode_RGB;
                if (up_rise && !down_rise && mode_q != '0)
                    mode_d = mode_q - 1'b1;
                else if (down_rise && !up_rise && mode_q != MODE_MAX)
                    mode_d = mode_q + 1'b1;
                if (enter_rise) state_d = S_CONTROLS;
            end
            S_CONTROLS: begin
                if (controls_DR) rgb_d = controls_RGB;
                if (enter_rise) begin
                    state_d = S_LEVEL_DSP;
                    cnt_d   = LVL_CNT;
                end
            end
            S_LEVEL_DSP: begin
                if (level_DR) rgb_d = level_RGB;
                game_on_d = 1'b0;
                // Zero-count check comes first so a coincident pulse cannot underflow.
                if (cnt_q == 4'd0) begin
                    state_d   = S_GAMEPLAY;
                    game_on_d = 1'b1;
                end else if (one_sec_pulse) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAMEPLAY: begin
                if (player_died || timer_ended) begin
                    state_d = S_GAMEOVER_DLY;
                    got_d   = player_died;
                    cnt_d   = DLY_CNT;
                end else if (level_cleared) begin
                    game_on_d = 1'b0;
                    if (level_q < LVL_LAST) begin
                        level_d = level_q + 1'b1;
                        state_d = S_LEVEL_DSP;
                        cnt_d   = LVL_CNT;
                    end else begin
                        state_d = S_GAME_WON;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (enter_rise) begin
                    state_d   = S_PAUSED;
                    game_on_d = 1'b0;
                    paused_d  = 1'b1;
                end
`endif
            end
            S_GAMEOVER_DLY: begin
                if (cnt_q == 4'd0) begin
                    state_d   = S_GAMEOVER;
                    game_on_d = 1'b0;
                end else if (one_sec_pulse) begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_GAMEOVER: begin
                if (gameover_DR) rgb_d = gameover_RGB;
                if (enter_rise) begin
                    state_d = S_MAIN_MENU;
                    mode_d  = '0;
                end
            end
            S_GAME_WON: begin
                if (won_DR) rgb_d = won_RGB;
                if (enter_rise) begin
                    state_d = S_MAIN_MENU;
                    mode_d  = '0;
                end
            end
`ifdef GAME_PAUSE_EN
            S_PAUSED: begin
                if (enter_rise) begin
                    state_d   = S_GAMEPLAY;
                    game_on_d = 1'b1;
                    paused_d  = 1'b0;
                end
            end
`endif
            default: state_d = S_MAIN_MENU;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= S_MAIN_MENU;
            cnt_q     <= 4'd0;
            rgb_q     <= 8'd0;
            game_on_q <= 1'b0;
            mode_q    <= '0;
            level_q   <= LVL_FIRST;
            got_q     <= 1'b0;
            enter_q   <= 1'b0;
            up_q      <= 1'b0;
            down_q    <= 1'b0;
`ifdef GAME_PAUSE_EN
            paused_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rgb_q     <= rgb_d;
            game_on_q <= game_on_d;
            mode_q    <= mode_d;
            level_q   <= level_d;
            got_q     <= got_d;
            enter_q   <= enter_key_pressed;
            up_q      <= up_key_pressed;
            down_q    <= down_key_pressed;
`ifdef GAME_PAUSE_EN
            paused_q  <= paused_d;
`endif
        end
    end

    assign RGBOut         = rgb_q;
    assign game_on        = game_on_q;
    assign mode_sel       = mode_q;
    assign level_sel      = level_q;
    assign game_over_type = got_q;
`ifdef GAME_PAUSE_EN
    assign paused         = paused_q;
`else
    assign paused         = 1'b0;
`endif

endmodule

// File: tb/tb_game_flow_sm.sv
// Directed bench for game_flow_sm with default parameters; pause checks active when GAME_PAUSE_EN is defined.
module tb_game_flow_sm;
  logic clk, resetN;
  logic enter_key_pressed, up_key_pressed, down_key_pressed;
  logic one_sec_pulse, timer_ended, player_died, level_cleared;
  logic menu_DR, mode_DR, controls_DR, level_DR, gameover_DR, won_DR;
  logic [7:0] menu_RGB, mode_RGB, controls_RGB, level_RGB, gameover_RGB, won_RGB, RGB_MIF;
  logic [7:0] RGBOut;
  logic game_on, game_over_type, paused;
  logic [0:0] mode_sel;
  logic [1:0] level_sel;

  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_err = 0;

  game_flow_sm dut (
    .clk(clk), .resetN(resetN),
    .enter_key_pressed(enter_key_pressed), .up_key_pressed(up_key_pressed),
    .down_key_pressed(down_key_pressed), .one_sec_pulse(one_sec_pulse),
    .timer_ended(timer_ended), .player_died(player_died), .level_cleared(level_cleared),
    .menu_DR(menu_DR), .menu_RGB(menu_RGB), .mode_DR(mode_DR), .mode_RGB(mode_RGB),
    .controls_DR(controls_DR), .controls_RGB(controls_RGB),
    .level_DR(level_DR), .level_RGB(level_RGB),
    .gameover_DR(gameover_DR), .gameover_RGB(gameover_RGB),
    .won_DR(won_DR), .won_RGB(won_RGB), .RGB_MIF(RGB_MIF),
    .RGBOut(RGBOut), .game_on(game_on), .mode_sel(mode_sel), .level_sel(level_sel),
    .game_over_type(game_over_type), .paused(paused)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: expected colour queued with the stimulus, popped when RGBOut is due
  task automatic expect_screen(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    tick();
    tick();
    e = exp_q.pop_front();
    check(tag, RGBOut, e);
  endtask

  task automatic expect_rgb_next(input string tag, input logic [7:0] exp);
    logic [7:0] e;
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    check(tag, RGBOut, e);
  endtask

  // driver tasks
  task automatic press_enter();
    enter_key_pressed = 1'b1; tick();
    enter_key_pressed = 1'b0; tick();
  endtask

  task automatic press_up();
    up_key_pressed = 1'b1; tick();
    up_key_pressed = 1'b0; tick();
  endtask

  task automatic press_down();
    down_key_pressed = 1'b1; tick();
    down_key_pressed = 1'b0; tick();
  endtask

  task automatic clear_level();
    level_cleared = 1'b1; tick();
    level_cleared = 1'b0;
  endtask

  task automatic banner(input string tag);
    one_sec_pulse = 1'b1;
    repeat (3) tick();
    one_sec_pulse = 1'b0;
    check({tag, "_on_at_zero"}, game_on, 1'b0);
    tick();
    check({tag, "_on_next"}, game_on, 1'b1);
  endtask

  initial begin
    resetN = 1'b0;
    enter_key_pressed = 0; up_key_pressed = 0; down_key_pressed = 0;
    one_sec_pulse = 0; timer_ended = 0; player_died = 0; level_cleared = 0;
    menu_DR = 1; mode_DR = 1; controls_DR = 1; level_DR = 1; gameover_DR = 1; won_DR = 1;
    menu_RGB = 8'h11; mode_RGB = 8'h22; controls_RGB = 8'h33; level_RGB = 8'h44;
    gameover_RGB = 8'h55; won_RGB = 8'h66; RGB_MIF = 8'h77;
    repeat (3) tick();

    check("rst_rgb", RGBOut, 8'h00);
    check("rst_game_on", game_on, 1'b0);
    check("rst_mode", mode_sel, 1'b0);
    check("rst_level", level_sel, 2'd1);
    check("rst_type", game_over_type, 1'b0);
    check("rst_paused", paused, 1'b0);
    resetN = 1'b1;

    // held enter advances exactly one screen
    enter_key_pressed = 1'b1;
    repeat (100) tick();
    expect_screen("held_enter_mode_sel", 8'h22);
    enter_key_pressed = 1'b0;
    tick();

    // mode select saturation
    check("mode_start", mode_sel, 1'b0);
    repeat (3) press_down();
    check("mode_down_sat", mode_sel, 1'b1);
    up_key_pressed = 1'b1; down_key_pressed = 1'b1; tick();
    up_key_pressed = 1'b0; down_key_pressed = 1'b0; tick();
    check("mode_up_down_same", mode_sel, 1'b1);
    press_up();
    press_up();
    check("mode_up_sat", mode_sel, 1'b0);
    press_down();
    press_enter();
    expect_screen("controls_screen", 8'h33);
    check("mode_held", mode_sel, 1'b1);

    // level 1 banner and gameplay
    press_enter();
    expect_screen("level_screen", 8'h44);
    check("banner_game_on", game_on, 1'b0);
    check("level1", level_sel, 2'd1);
    banner("b1");
    expect_screen("gameplay_mif", 8'h77);

`ifdef GAME_PAUSE_EN
    press_enter();
    check("pause_paused", paused, 1'b1);
    check("pause_game_on", game_on, 1'b0);
    player_died = 1'b1; tick();
    player_died = 1'b0; tick();
    check("pause_died_ignored", paused, 1'b1);
    check("pause_died_game_on", game_on, 1'b0);
    press_enter();
    check("resume_paused", paused, 1'b0);
    check("resume_game_on", game_on, 1'b1);
`else
    press_enter();
    check("enter_ignored_game_on", game_on, 1'b1);
    check("enter_ignored_paused", paused, 1'b0);
`endif

    // level progression; pulse coinciding with zero count must not underflow
    clear_level();
    check("level2", level_sel, 2'd2);
    check("level2_game_on", game_on, 1'b0);
    expect_screen("level2_screen", 8'h44);
    one_sec_pulse = 1'b1;
    repeat (4) tick();
    one_sec_pulse = 1'b0;
    check("b2_pulse_at_zero", game_on, 1'b1);
    tick();
    check("b2_stays_on", game_on, 1'b1);
    clear_level();
    check("level3", level_sel, 2'd3);
    banner("b3");
    clear_level();
    check("won_game_on", game_on, 1'b0);
    check("won_level", level_sel, 2'd3);
    check("won_mode", mode_sel, 1'b1);
    expect_screen("won_screen", 8'h66);
    press_enter();
    check("menu_mode_clr", mode_sel, 1'b0);
    check("menu_level_1", level_sel, 2'd1);
    expect_screen("menu_screen", 8'h11);

    // colour path
    menu_DR = 1'b0;
    expect_screen("menu_dr0_mif", 8'h77);
    menu_DR = 1'b1; menu_RGB = 8'h99;
    expect_rgb_next("rgb_latency", 8'h99);
    menu_RGB = 8'h11;

    // death and timeout together: lives-lost wins, type latched
    press_enter();
    press_enter();
    press_enter();
    banner("b4");
    player_died = 1'b1; timer_ended = 1'b1; tick();
    player_died = 1'b0;
    check("dly_type_died", game_over_type, 1'b1);
    check("dly_game_on", game_on, 1'b1);
    expect_screen("dly_mif", 8'h77);
    one_sec_pulse = 1'b1;
    repeat (3) tick();
    one_sec_pulse = 1'b0;
    check("dly_zero_on", game_on, 1'b1);
    tick();
    timer_ended = 1'b0;
    check("gameover_off", game_on, 1'b0);
    check("gameover_type_latched", game_over_type, 1'b1);
    expect_screen("gameover_screen", 8'h55);
    press_enter();
    expect_screen("gameover_to_menu", 8'h11);

    // timeout only, then reset mid-operation
    press_enter();
    press_down();
    press_enter();
    press_enter();
    banner("b5");
    timer_ended = 1'b1; tick();
    timer_ended = 1'b0;
    check("timeout_type", game_over_type, 1'b0);
    check("timeout_game_on", game_on, 1'b1);
    check("timeout_mode", mode_sel, 1'b1);
    resetN = 1'b0;
    #1;
    check("midrst_game_on", game_on, 1'b0);
    check("midrst_mode", mode_sel, 1'b0);
    check("midrst_rgb", RGBOut, 8'h00);
    tick();
    resetN = 1'b1;
    expect_screen("midrst_menu", 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
